// File: rtl/avm_resp_pkg.sv
// Shared types and constants for the Avalon-MM SDRAM stand-in responder.
package avm_resp_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int BANK_W = 2;
  localparam int TMR_W  = 16;

  localparam int DEF_MEM_AW         = 12;
  localparam int DEF_RD_LATENCY     = 3;
  localparam int DEF_ROW_LSB        = 9;
  localparam int DEF_TRCD           = 3;
  localparam int DEF_REFRESH_PERIOD = 780;
  localparam int DEF_REFRESH_CYCLES = 8;
  localparam int DEF_INIT_CYCLES    = 16;

  typedef enum logic [3:0] {
    ST_INIT     = 4'b0001,
    ST_READY    = 4'b0010,
    ST_ACTIVATE = 4'b0100,
    ST_REFRESH  = 4'b1000
  } state_e;

  // Bank field of a word address; the bank is part of the open-row tag.
  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: BANK_W];
  endfunction

endpackage

// File: rtl/avm_rd_pipe.sv
// Valid+data delay line behind the RAM read register; each stage only
// loads data when its input is valid so the output holds its last word.
module avm_rd_pipe #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_vld_o,
  output logic [DATA_W-1:0] out_data_o
);

  logic [DEPTH-1:0]  vld_q;
  logic [DATA_W-1:0] data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld_i;
      if (in_vld_i) data_q[0] <= in_data_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_vld_o  = vld_q[DEPTH-1];
  assign out_data_o = data_q[DEPTH-1];

endmodule

// File: rtl/avm_sdram_responder.sv
// Avalon-MM responder mimicking SDRAM controller IP: init, row-activate and
// refresh stalls on waitrequest, fixed-latency reads from an inline RAM.
//
// state    | meaning
// ST_INIT  | post-reset power-up wait, always stalled
// ST_READY | serving requests; stalls while a miss/refresh is decided
// ST_ACTIVATE | opening the row presented on avm_addr
// ST_REFRESH  | auto-refresh in progress, open row is lost
module avm_sdram_responder
  import avm_resp_pkg::*;
#(
  parameter int MEM_AW         = DEF_MEM_AW,
  parameter int RD_LATENCY     = DEF_RD_LATENCY,
  parameter int ROW_LSB        = DEF_ROW_LSB,
  parameter int TRCD           = DEF_TRCD,
  parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int INIT_CYCLES    = DEF_INIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              avm_write,
  input  logic              avm_read,
  input  logic [ADDR_W-1:0] avm_addr,
  input  logic [DATA_W-1:0] avm_wrdata,
  output logic [DATA_W-1:0] avs_rddata,
  output logic              avs_rddata_vld,
  output logic              avs_waitrequest,
  output logic              proto_err
);

  localparam int ROW_W = ADDR_W - ROW_LSB;
  localparam int RC_W  = $clog2(REFRESH_PERIOD);

  // The READY cycle that detects a miss/refresh already stalls, so the
  // busy states run one cycle short of the full stall length.
  localparam logic [TMR_W-1:0] INIT_LD = TMR_W'(INIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] ACT_LD  = TMR_W'(TRCD - 2);
  localparam logic [TMR_W-1:0] REF_LD  = TMR_W'(REFRESH_CYCLES - 2);
  localparam logic [RC_W-1:0]  REF_TC  = RC_W'(REFRESH_PERIOD - 1);

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [ROW_W-1:0]  open_row_q, open_row_d;
  logic              row_valid_q, row_valid_d;
  logic [RC_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic              ref_pend_q, ref_pend_d;
  logic              ref_clr;
  logic              ref_wrap;
  logic              proto_err_q;

  logic              req, row_miss, accept, wr_acc, rd_acc;
  logic [ROW_W-1:0]  req_row;
  logic [BANK_W-1:0] req_bank;

  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_vld_q;
  logic              pipe_vld;
  logic [DATA_W-1:0] pipe_data;

  assign req      = ~avm_write | ~avm_read;
  assign req_row  = avm_addr[ADDR_W-1:ROW_LSB];
  assign req_bank = bank_of(avm_addr);
  assign row_miss = ~row_valid_q | (req_row != open_row_q);

  assign avs_waitrequest = rst | (state_q != ST_READY) | (req & (row_miss | ref_pend_q));
  assign accept          = req & ~avs_waitrequest;
  // Both strobes low is treated as a write only.
  assign wr_acc          = accept & ~avm_write;
  assign rd_acc          = accept & avm_write & ~avm_read;

  assign ref_wrap  = (ref_cnt_q == REF_TC);
  assign ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
  assign ref_pend_d = ref_wrap | (ref_pend_q & ~ref_clr);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    open_row_d  = open_row_q;
    row_valid_d = row_valid_q;
    ref_clr     = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (timer_q == '0) state_d = ST_READY;
        else               timer_d = timer_q - 1'b1;
      end
      ST_READY: begin
        if (ref_pend_q) begin
          state_d = ST_REFRESH;
          timer_d = REF_LD;
        end else if (req & row_miss) begin
          state_d = ST_ACTIVATE;
          timer_d = ACT_LD;
        end
      end
      ST_ACTIVATE: begin
        if (timer_q == '0) begin
          state_d     = ST_READY;
          open_row_d  = req_row;
          row_valid_d = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_REFRESH: begin
        if (timer_q == '0) begin
          state_d     = ST_READY;
          ref_clr     = 1'b1;
          row_valid_d = 1'b0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d     = ST_INIT;
        timer_d     = INIT_LD;
        row_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      timer_q     <= INIT_LD;
      open_row_q  <= '0;
      row_valid_q <= 1'b0;
      ref_cnt_q   <= '0;
      ref_pend_q  <= 1'b0;
      proto_err_q <= 1'b0;
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      open_row_q  <= open_row_d;
      row_valid_q <= row_valid_d;
      ref_cnt_q   <= ref_cnt_d;
      ref_pend_q  <= ref_pend_d;
      rd_vld_q    <= rd_acc;
      if (~avm_write & ~avm_read) proto_err_q <= 1'b1;
    end
  end

  // Single-port synchronous RAM; upper address bits alias onto it.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[avm_addr[MEM_AW-1:0]] <= avm_wrdata;
    rd_data_q <= mem[avm_addr[MEM_AW-1:0]];
  end

  avm_rd_pipe #(
    .DEPTH  (RD_LATENCY - 1),
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_vld_i   (rd_vld_q),
    .in_data_i  (rd_data_q),
    .out_vld_o  (pipe_vld),
    .out_data_o (pipe_data)
  );

  // In-flight reads vanish in the very cycle reset is raised.
  assign avs_rddata_vld = pipe_vld & ~rst;
  assign avs_rddata     = pipe_data;
  assign proto_err      = proto_err_q;

  logic unused_ok;
  assign unused_ok = ^req_bank;

endmodule

// File: tb/tb_avm_sdram_responder.sv
// Self-checking bench: table-driven directed transfers, reset/refresh
// sequences and randomized traffic checked against a memory/latency model.
module tb_avm_sdram_responder;

  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        avm_write = 1'b1;
  logic        avm_read = 1'b1;
  logic [23:0] avm_addr = '0;
  logic [15:0] avm_wrdata = '0;
  logic [15:0] avs_rddata;
  logic        avs_rddata_vld;
  logic        avs_waitrequest;
  logic        proto_err;

  avm_sdram_responder dut (
    .clk             (clk),
    .rst             (rst),
    .avm_write       (avm_write),
    .avm_read        (avm_read),
    .avm_addr        (avm_addr),
    .avm_wrdata      (avm_wrdata),
    .avs_rddata      (avs_rddata),
    .avs_rddata_vld  (avs_rddata_vld),
    .avs_waitrequest (avs_waitrequest),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  // cyc = 1 in the first cycle after the last reset edge
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 1;
    else     cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: word memory indexed by the low 12 address bits and a
  // queue of reads due RD_LAT cycles after acceptance.
  typedef struct {
    int          due;
    logic [15:0] data;
    bit          known;
  } rd_t;

  rd_t         rdq[$];
  logic [15:0] mdl_mem [4096];
  bit          mdl_known [4096];
  logic [15:0] last_data = '0;
  bit          last_known = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        rdq.delete();
        last_data  = '0;
        last_known = 1'b1;
        chk("vld_during_reset", avs_rddata_vld, 0);
      end else begin
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
          rd_t e;
          e = rdq.pop_front();
          chk($sformatf("rd_vld@%0d", cyc), avs_rddata_vld, 1);
          if (e.known) chk($sformatf("rd_data@%0d", cyc), avs_rddata, e.data);
          last_data  = e.data;
          last_known = e.known;
        end else begin
          chk($sformatf("rd_vld_spurious@%0d", cyc), avs_rddata_vld, 0);
          if (last_known) chk($sformatf("rddata_hold@%0d", cyc), avs_rddata, last_data);
        end
        if ((!avm_write || !avm_read) && !avs_waitrequest) begin
          int idx;
          idx = int'(avm_addr[11:0]);
          if (!avm_write) begin
            mdl_mem[idx]   = avm_wrdata;
            mdl_known[idx] = 1'b1;
          end else begin
            rd_t r;
            r.due   = cyc + RD_LAT;
            r.data  = mdl_mem[idx];
            r.known = mdl_known[idx];
            rdq.push_back(r);
          end
        end
      end
    end
  end

  // Presents one request, holds it while stalled, returns after the accept edge.
  task automatic xfer(input bit wr, input bit rd, input logic [23:0] a,
                      input logic [15:0] d, output int stalls, output int acc);
    avm_write  = ~wr;
    avm_read   = ~rd;
    avm_addr   = a;
    avm_wrdata = d;
    stalls = 0;
    acc    = -1;
    for (int i = 0; i < 2000 && acc < 0; i++) begin
      @(negedge clk);
      if (avs_waitrequest) stalls++;
      else acc = cyc;
      @(posedge clk);
      #1;
    end
    avm_write = 1'b1;
    avm_read  = 1'b1;
    if (acc < 0) begin
      n_checks++;
      $display("FAIL xfer_timeout: addr=%06h not accepted within 2000 cycles", a);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [23:0] addr;
    logic [15:0] data;
    int          exp_stalls;
    bit          exp_proto;
  } vec_t;

  vec_t tbl[22];

  initial begin
    int s, a;
    int nst, st_val, st_acc, k;

    for (int i = 0; i < 8; i++) begin
      tbl[i]   = '{1'b1, 1'b0, 24'h000100 + 24'(i), 16'hA000 + 16'(i), 0, 1'b0};
      tbl[8+i] = '{1'b0, 1'b1, 24'h000100 + 24'(i), 16'h0000, 0, 1'b0};
    end
    tbl[16] = '{1'b1, 1'b0, 24'h400010, 16'h1234, 3, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 24'h000010, 16'h0000, 3, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 24'h000020, 16'hBEEF, 0, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 24'h000020, 16'h0000, 0, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 24'h000107, 16'h0000, 0, 1'b1};
    tbl[21] = '{1'b0, 1'b1, 24'h400010, 16'h0000, 3, 1'b1};

    // reset values
    idle(3);
    chk("rst_waitrequest", avs_waitrequest, 1);
    chk("rst_vld", avs_rddata_vld, 0);
    chk("rst_rddata", avs_rddata, 0);
    chk("rst_proto_err", proto_err, 0);

    // init + first activate: 19 stalled cycles, accept in cycle 20
    rst = 1'b0;
    xfer(1'b0, 1'b1, 24'h000000, 16'h0, s, a);
    chk("init_stalls", s, 19);
    chk("init_accept_cyc", a, 20);

    for (int i = 0; i < 22; i++) begin
      xfer(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, s, a);
      chk($sformatf("tbl%0d_stalls", i), s, tbl[i].exp_stalls);
      chk($sformatf("tbl%0d_proto_err", i), proto_err, tbl[i].exp_proto);
    end
    idle(4);
    chk("proto_err_sticky", proto_err, 1);

    // reset with two reads in flight
    xfer(1'b0, 1'b1, 24'h000100, 16'h0, s, a);
    xfer(1'b0, 1'b1, 24'h000101, 16'h0, s, a);
    rst = 1'b1;
    idle(1);
    chk("midrst_waitrequest", avs_waitrequest, 1);
    chk("midrst_proto_err", proto_err, 0);
    chk("midrst_rddata", avs_rddata, 0);
    idle(5);
    rst = 1'b0;
    xfer(1'b0, 1'b1, 24'h000100, 16'h0, s, a);
    chk("reinit_stalls", s, 19);
    chk("reinit_accept_cyc", a, 20);

    // stream reads across the first refresh (pending visible in cycle 781)
    nst = 0; st_val = 0; st_acc = 0; k = 1; a = 20;
    while (a >= 0 && a < 800) begin
      xfer(1'b0, 1'b1, 24'h000100 + 24'(k % 8), 16'h0, s, a);
      if (s != 0) begin
        nst++;
        st_val = s;
        st_acc = a;
      end
      k++;
    end
    chk("refresh_stall_events", nst, 1);
    chk("refresh_plus_act_stalls", st_val, 11);
    chk("refresh_resume_cyc", st_acc, 792);
    chk("proto_err_after_rst", proto_err, 0);

    // randomized traffic over aliasing rows
    for (int i = 0; i < 800; i++) begin
      int r;
      logic [23:0] ra;
      r  = int'($urandom_range(0, 99));
      ra = (24'($urandom_range(0, 3)) << 20) | (24'($urandom_range(0, 1)) << 9)
           | 24'($urandom_range(0, 15));
      if (r < 45)      xfer(1'b1, 1'b0, ra, 16'($urandom), s, a);
      else if (r < 90) xfer(1'b0, 1'b1, ra, 16'h0, s, a);
      else             idle(int'($urandom_range(1, 3)));
    end

    idle(RD_LAT + 2);
    chk("rd_queue_drained", rdq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
